// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bus bundle: ICache request/response, predictor, RoB redirect and decoder queue head.
// The master modport is the fetch queue; the slave modport is its environment.
interface inst_fetch_queue_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_WIDTH  = 32
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  rob_clear;
  logic [ADDR_WIDTH-1:0] rob_newpc;
  logic                  jalr_done;
  logic [ADDR_WIDTH-1:0] jalr_pc;
  logic                  ic_req_valid;
  logic [ADDR_WIDTH-1:0] ic_req_pc;
  logic                  ic_hit;
  logic [31:0]           ic_inst;
  logic [ADDR_WIDTH-1:0] pre_pc;
  logic                  pre_jump;
  logic                  dc_valid;
  logic                  dc_ready;
  logic [31:0]           dc_inst;
  logic [ADDR_WIDTH-1:0] dc_pc;
  logic                  dc_isjump;
  logic [CNT_W-1:0]      q_count;

  modport master (
    input  rob_clear, rob_newpc, jalr_done, jalr_pc, ic_hit, ic_inst, pre_jump, dc_ready,
    output ic_req_valid, ic_req_pc, pre_pc, dc_valid, dc_inst, dc_pc, dc_isjump, q_count
  );

  modport slave (
    output rob_clear, rob_newpc, jalr_done, jalr_pc, ic_hit, ic_inst, pre_jump, dc_ready,
    input  ic_req_valid, ic_req_pc, pre_pc, dc_valid, dc_inst, dc_pc, dc_isjump, q_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: local next-PC, back-to-back ICache requests, decoupled queue.
// Define IFQ_JALR_STALL_EN to stall fetching on JALR until the RoB resolves the target.
module inst_fetch_queue #(
  parameter int                    QUEUE_DEPTH = 4,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  inst_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {IDLE, WAIT, JALR_WAIT} state_e;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  jump;
  } entry_t;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]      req_pc_q, req_pc_d;
  logic                       req_valid_q, req_valid_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d, count_after;
  entry_t [QUEUE_DEPTH-1:0]   mem_q, mem_d;
  entry_t                     head;

  logic                  push, pop, isjump, jalr_stall;
  logic [ADDR_WIDTH-1:0] next_pc;

  function automatic logic [ADDR_WIDTH-1:0] imm_j(input logic [31:0] i);
    return {{(ADDR_WIDTH-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] imm_b(input logic [31:0] i);
    return {{(ADDR_WIDTH-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // A flush discards any same-cycle hit or pop.
  assign push        = rdy_in && !bus.rob_clear && (state_q == WAIT) && bus.ic_hit;
  assign pop         = rdy_in && !bus.rob_clear && (count_q != '0) && bus.dc_ready;
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    next_pc    = pc_q + ADDR_WIDTH'(4);
    isjump     = 1'b0;
    jalr_stall = 1'b0;
    case (bus.ic_inst[6:0])
      OP_JAL: begin
        next_pc = pc_q + imm_j(bus.ic_inst);
        isjump  = 1'b1;
      end
      OP_BR: begin
        if (bus.pre_jump) begin
          next_pc = pc_q + imm_b(bus.ic_inst);
          isjump  = 1'b1;
        end
      end
`ifdef IFQ_JALR_STALL_EN
      OP_JALR: jalr_stall = 1'b1;
`else
      OP_JALR: jalr_stall = 1'b0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    if (bus.rob_clear) begin
      state_d     = IDLE;
      pc_d        = bus.rob_newpc;
      req_valid_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else if (rdy_in) begin
      count_d = count_after;
      if (push) begin
        mem_d[wr_ptr_q] = '{inst: bus.ic_inst, pc: pc_q, jump: isjump};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case (state_q)
        IDLE: begin
          if (count_after < DEPTH_C) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (bus.ic_hit) begin
            pc_d = next_pc;
            // Keep the request level high and just retarget it while a slot stays reserved.
            if (!jalr_stall && (count_after < DEPTH_C)) begin
              req_pc_d = next_pc;
            end else begin
              req_valid_d = 1'b0;
              state_d     = jalr_stall ? JALR_WAIT : IDLE;
            end
          end
        end
`ifdef IFQ_JALR_STALL_EN
        JALR_WAIT: begin
          if (bus.jalr_done) begin
            pc_d    = bus.jalr_pc;
            state_d = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

`ifndef IFQ_JALR_STALL_EN
  logic unused_jalr;
  assign unused_jalr = ^{bus.jalr_done, bus.jalr_pc};
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  // Head fields read as zero whenever the queue is empty.
  assign head             = mem_q[rd_ptr_q];
  assign bus.dc_valid     = (count_q != '0);
  assign bus.dc_inst      = bus.dc_valid ? head.inst : '0;
  assign bus.dc_pc        = bus.dc_valid ? head.pc : '0;
  assign bus.dc_isjump    = bus.dc_valid && head.jump;
  assign bus.q_count      = count_q;
  assign bus.ic_req_valid = req_valid_q;
  assign bus.ic_req_pc    = req_pc_q;
  assign bus.pre_pc       = req_pc_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table for the main flow plus
// hand sequences for full queue, flush, JALR and asynchronous reset.
module tb_inst_fetch_queue;
  localparam int AW = 32;
  localparam int QD = 4;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'hFF9F_F06F;  // jal x0, -8
  localparam logic [31:0] BEQ  = 32'h0200_0063;  // beq x0, x0, +0x20
  localparam logic [31:0] JALR = 32'h0000_8067;  // jalr x0, 0(x1)

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.QUEUE_DEPTH(QD), .ADDR_WIDTH(AW)) bus ();

  inst_fetch_queue #(.QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic rdy, clr; logic [31:0] npc; logic hit; logic [31:0] inst; logic pj, dcr;
    logic rv; logic [31:0] rpc; logic dv; logic [31:0] dpc; logic dj; logic [31:0] dinst; int cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy_i, clr, input logic [31:0] npc, input logic hit,
                              input logic [31:0] inst, input logic pj, dcr, input logic rv,
                              input logic [31:0] rpc, input logic dv, input logic [31:0] dpc,
                              input logic dj, input logic [31:0] dinst, input int cnt);
    vec_t v;
    v.rdy = rdy_i; v.clr = clr; v.npc = npc; v.hit = hit; v.inst = inst; v.pj = pj; v.dcr = dcr;
    v.rv = rv; v.rpc = rpc; v.dv = dv; v.dpc = dpc; v.dj = dj; v.dinst = dinst; v.cnt = cnt;
    return v;
  endfunction

  task automatic check_out(input string tag, input logic rv, input logic [31:0] rpc,
                           input logic dv, input logic [31:0] dpc, input logic dj,
                           input logic [31:0] dinst, input int cnt);
    chk({tag, ".req_valid"}, 32'(bus.ic_req_valid), 32'(rv));
    chk({tag, ".req_pc"}, bus.ic_req_pc, rpc);
    chk({tag, ".dc_valid"}, 32'(bus.dc_valid), 32'(dv));
    chk({tag, ".dc_pc"}, bus.dc_pc, dpc);
    chk({tag, ".dc_isjump"}, 32'(bus.dc_isjump), 32'(dj));
    chk({tag, ".dc_inst"}, bus.dc_inst, dinst);
    chk({tag, ".q_count"}, 32'(bus.q_count), 32'(cnt));
  endtask

  initial begin
    bus.rob_clear = 1'b0; bus.rob_newpc = '0; bus.jalr_done = 1'b0; bus.jalr_pc = '0;
    bus.ic_hit = 1'b0; bus.ic_inst = '0; bus.pre_jump = 1'b0; bus.dc_ready = 1'b0;

    // Inputs applied before a rising edge; expected outputs sampled on the next falling edge.
    //           rdy clr npc       hit inst  pj dcr  rv rpc       dv dpc       dj dinst cnt
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'h0,   0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 0, 0,        1, ADDI, 0, 1,  1, 32'h4,   1, 32'h0,    0, ADDI, 1));
    vecs.push_back(mk(1, 0, 0,        1, ADDI, 0, 1,  1, 32'h8,   1, 32'h4,    0, ADDI, 1));
    vecs.push_back(mk(1, 0, 0,        1, ADDI, 0, 1,  1, 32'hC,   1, 32'h8,    0, ADDI, 1));
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'hC,   0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 1, 32'h100,  0, 0,    0, 1,  0, 32'hC,   0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'h100, 0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 0, 0,        1, JAL,  0, 1,  1, 32'hF8,  1, 32'h100,  1, JAL,  1));
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'hF8,  0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 1, 32'h200,  0, 0,    0, 1,  0, 32'hF8,  0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'h200, 0, 0,        0, 0,    0));
    vecs.push_back(mk(1, 0, 0,        1, BEQ,  1, 1,  1, 32'h220, 1, 32'h200,  1, BEQ,  1));
    vecs.push_back(mk(1, 0, 0,        1, BEQ,  0, 1,  1, 32'h224, 1, 32'h220,  0, BEQ,  1));
    vecs.push_back(mk(1, 0, 0,        1, ADDI, 0, 1,  1, 32'h228, 1, 32'h224,  0, ADDI, 1));
    vecs.push_back(mk(0, 0, 0,        1, ADDI, 0, 1,  1, 32'h228, 1, 32'h224,  0, ADDI, 1));
    vecs.push_back(mk(1, 0, 0,        0, 0,    0, 1,  1, 32'h228, 0, 0,        0, 0,    0));

    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rdy = vecs[i].rdy; bus.rob_clear = vecs[i].clr; bus.rob_newpc = vecs[i].npc;
      bus.ic_hit = vecs[i].hit; bus.ic_inst = vecs[i].inst; bus.pre_jump = vecs[i].pj;
      bus.dc_ready = vecs[i].dcr;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rpc, vecs[i].dv, vecs[i].dpc,
                vecs[i].dj, vecs[i].dinst, vecs[i].cnt);
    end

    // Full queue with decoder stalled, then a single pop reopens fetch at 0x10.
    rdy = 1'b1; bus.ic_hit = 1'b0; bus.pre_jump = 1'b0; bus.dc_ready = 1'b0;
    bus.rob_clear = 1'b1; bus.rob_newpc = 32'h0;
    @(negedge clk);
    bus.rob_clear = 1'b0;
    @(negedge clk);
    chk("full.first_req_valid", 32'(bus.ic_req_valid), 32'h1);
    chk("full.first_req_pc", bus.ic_req_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.ic_hit = 1'b1; bus.ic_inst = ADDI;
      @(negedge clk);
      chk($sformatf("full.count%0d", i), 32'(bus.q_count), 32'(i + 1));
    end
    chk("full.req_valid_low", 32'(bus.ic_req_valid), 32'h0);
    @(negedge clk);
    chk("full.hit_ignored_count", 32'(bus.q_count), 32'h4);
    chk("full.still_idle", 32'(bus.ic_req_valid), 32'h0);
    bus.ic_hit = 1'b0; bus.dc_ready = 1'b1;
    @(negedge clk);
    bus.dc_ready = 1'b0;
    chk("full.pop_count", 32'(bus.q_count), 32'h3);
    chk("full.reissue_valid", 32'(bus.ic_req_valid), 32'h1);
    chk("full.reissue_pc", bus.ic_req_pc, 32'h10);
    chk("full.head_pc", bus.dc_pc, 32'h4);

    // Flush with three entries queued while a hit is presented.
    bus.rob_clear = 1'b1; bus.rob_newpc = 32'h1000; bus.ic_hit = 1'b1; bus.ic_inst = ADDI;
    @(negedge clk);
    bus.rob_clear = 1'b0; bus.ic_hit = 1'b0;
    chk("clr.count", 32'(bus.q_count), 32'h0);
    chk("clr.dc_valid", 32'(bus.dc_valid), 32'h0);
    chk("clr.req_valid", 32'(bus.ic_req_valid), 32'h0);
    @(negedge clk);
    chk("clr.req_valid_t2", 32'(bus.ic_req_valid), 32'h1);
    chk("clr.req_pc_t2", bus.ic_req_pc, 32'h1000);

    // JALR at 0x40.
    bus.rob_clear = 1'b1; bus.rob_newpc = 32'h40;
    @(negedge clk);
    bus.rob_clear = 1'b0;
    @(negedge clk);
    chk("jalr.req_pc", bus.ic_req_pc, 32'h40);
    bus.ic_hit = 1'b1; bus.ic_inst = JALR;
    @(negedge clk);
    bus.ic_hit = 1'b0;
    chk("jalr.count", 32'(bus.q_count), 32'h1);
    chk("jalr.dc_pc", bus.dc_pc, 32'h40);
    chk("jalr.isjump", 32'(bus.dc_isjump), 32'h0);
`ifdef IFQ_JALR_STALL_EN
    chk("jalr.stall_valid", 32'(bus.ic_req_valid), 32'h0);
    repeat (2) @(negedge clk);
    chk("jalr.still_stalled", 32'(bus.ic_req_valid), 32'h0);
    bus.jalr_done = 1'b1; bus.jalr_pc = 32'h80;
    @(negedge clk);
    bus.jalr_done = 1'b0;
    chk("jalr.t1_valid", 32'(bus.ic_req_valid), 32'h0);
    @(negedge clk);
    chk("jalr.t2_valid", 32'(bus.ic_req_valid), 32'h1);
    chk("jalr.t2_pc", bus.ic_req_pc, 32'h80);
`else
    chk("jalr.nt_valid", 32'(bus.ic_req_valid), 32'h1);
    chk("jalr.nt_pc", bus.ic_req_pc, 32'h44);
`endif

    // Asynchronous reset between edges while a request is outstanding.
    #2 rst_n = 1'b0;
    #1;
    chk("areset.req_valid", 32'(bus.ic_req_valid), 32'h0);
    chk("areset.dc_valid", 32'(bus.dc_valid), 32'h0);
    chk("areset.count", 32'(bus.q_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset.first_valid", 32'(bus.ic_req_valid), 32'h1);
    chk("areset.first_pc", bus.ic_req_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end with a decoupled instruction queue between the ICache and the Decoder. It computes the next PC locally (JAL target, predictor-steered branch target, PC+4) and keeps one ICache request in flight back-to-back. It also buffers up to `QUEUE_DEPTH` fetched instructions so Decoder back-pressure does not stall the cache. It sits between ICache/Predictor and Decoder, and is redirected by RoB on mispredict.

## Interface
- `QUEUE_DEPTH`, 4, queue entries; power of two, ≥2
- `ADDR_WIDTH`, 32, PC width
- `RESET_PC`, 0, PC after reset
- `clk_in` in 1: clock, rising edge
- `rst_n_in` in 1: asynchronous, active-low reset
- `rdy_in` in 1: global enable; low freezes the block except `rob_clear`
- `rob_clear` in 1: flush and redirect
- `rob_newpc` in ADDR_WIDTH: redirect target
- `jalr_done` in 1: JALR target resolved
- `jalr_pc` in ADDR_WIDTH: resolved JALR target
- `ic_req_valid` out 1: fetch request (level)
- `ic_req_pc` out ADDR_WIDTH: fetch address
- `ic_hit` in 1: ICache returns `ic_inst` for `ic_req_pc` this cycle
- `ic_inst` in 32: instruction word
- `pre_pc` out ADDR_WIDTH: equals `ic_req_pc` (wire), for same-cycle prediction
- `pre_jump` in 1: predictor taken
- `dc_valid` out 1: queue head valid (`count != 0`)
- `dc_ready` in 1: Decoder accepts head
- `dc_inst` out 32, `dc_pc` out ADDR_WIDTH, `dc_isjump` out 1: head entry
- `q_count` out $clog2(QUEUE_DEPTH)+1: occupancy

## Operation
- States: IDLE, WAIT (request outstanding), JALR_WAIT.
- IDLE: if `count < QUEUE_DEPTH`, set `ic_req_valid`=1 and `ic_req_pc`=PC, then go to WAIT.
- WAIT: hold the request until `ic_hit`. On hit:
  - Push {`ic_inst`, PC, isjump}.
  - Compute next PC:
    - opcode 1101111 (JAL): next = PC+immJ, isjump=1.
    - opcode 1100011 (B): if `pre_jump`, next = PC+immB, isjump=1; otherwise PC+4, isjump=0.
    - opcode 1100111 (JALR): see Configuration.
    - All others: next = PC+4, isjump=0.
  - PC ← next.
  - If no JALR stall and (count+1−pop) < QUEUE_DEPTH: stay in WAIT with `ic_req_pc` ← next (back-to-back). Otherwise `ic_req_valid` ← 0 and go to IDLE (or JALR_WAIT).
- The ICache must accept an `ic_req_pc` change while `ic_req_valid` stays high. `ic_hit` is ignored outside WAIT.
- immJ = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}. immB = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}. Additions wrap modulo 2^ADDR_WIDTH.
- Pop when `dc_valid && dc_ready`. Simultaneous push and pop leaves count unchanged. Push never overflows because a request issues only when a slot is reserved. Pointers wrap at QUEUE_DEPTH.
- JALR_WAIT: on `jalr_done`, PC ← `jalr_pc` and go to IDLE. `jalr_done` is ignored in other states.
- `rob_clear` (priority over everything except reset, independent of `rdy_in`):
  - Pointers and count ← 0, PC ← `rob_newpc`, `ic_req_valid` ← 0, state ← IDLE.
  - A same-cycle `ic_hit`, pop or `jalr_done` is discarded.
- Reset values: PC=RESET_PC, state IDLE, `ic_req_valid`=0, `ic_req_pc`=0, count=0 (so `dc_valid`=0), queue outputs 0.

## Timing
- Request issue: one cycle after entering IDLE with a free slot.
- Hit in cycle t: entry visible on `dc_*` in t+1. With back-to-back enabled, the next request is presented in t+1, so the steady state is one instruction per hit cycle.
- Full queue: `ic_req_valid` stays low until a pop frees a slot. Issue happens the cycle after that pop.
- `rob_clear` in cycle t: `dc_valid`=0 in t+1. A new request for `rob_newpc` appears in t+2.
- JALR: `jalr_done` in t gives a request for `jalr_pc` in t+2.

## Configuration
- `IFQ_JALR_STALL_EN` defined: on JALR, push with isjump=0, PC ← PC+4, go to JALR_WAIT, and issue no fetches until `jalr_done` or `rob_clear`.
- `IFQ_JALR_STALL_EN` undefined: JALR is treated as not-taken (next = PC+4, isjump=0) and fetching continues. `jalr_done`/`jalr_pc` are unused, JALR_WAIT is unreachable, and RoB corrects via `rob_clear`.

## Test plan
- Reset, `dc_ready`=1, 1-cycle-hit cache returning ADDI: requests at 0, 4, 8, … on consecutive cycles; `dc_pc` follows the same sequence; `q_count` ≤ 1.
- `dc_ready`=0, DEPTH=4: exactly 4 hits accepted, `q_count`=4, `ic_req_valid`=0. Raise `dc_ready` for one cycle: one pop, and the next request is for PC 0x10.
- JAL at 0x100 with imm −8: next `ic_req_pc`=0xF8, `dc_isjump`=1. BEQ at 0x200, imm +0x20, `pre_jump`=1: next request 0x220. With `pre_jump`=0: next request 0x204.
- JALR at 0x40 (macro on): no requests until `jalr_done` with `jalr_pc`=0x80; request at 0x80 two cycles later. Macro off: next request 0x44.
- Queue holding 3 entries, `rob_clear`=1 with `rob_newpc`=0x1000 while `ic_hit` is high: hit discarded, `q_count`=0 next cycle, request 0x1000 the cycle after.
- `rst_n_in` asserted mid-WAIT, asynchronously between clock edges: `ic_req_valid`=0, `dc_valid`=0 immediately. After release, the first request is at RESET_PC.
